elastic_read_ctrl: RTL and testbench
====================================

Name: elastic_read_ctrl

Overview:
- Read-side controller for the RX elastic buffer, clocked in the recovered/local read domain.
- Generates the binary read address and its Gray copy, tracks fill level against the synchronised Gray write pointer, and performs SKP-based clock compensation.
- Insertion repeats a SKP symbol by holding the pointer; deletion consumes a SKP without presenting it.
- Sits between the buffer RAM read port and the decoder; the matching write-side controller receives gray_read_pointer through its synchroniser.

Parameters:
- DATA_WIDTH, 10, symbol width.
- BUFFER_DEPTH, 16, entries; power of two, >= 4.
- SKP_RD_NEG, 10'b0011111001, SKP symbol, RD- encoding (DATA_WIDTH bits).
- SKP_RD_POS, 10'b1100000110, SKP symbol, RD+ encoding.
- MAX_INS, 2, maximum SKPs inserted per SKP run.
- MIN_SKP_KEEP, 1, SKPs of a run that must pass before deletion is allowed.

Ports:
- read_clk  in  1  read-domain clock.
- rst  in  1  synchronous, active-high reset.
- gray_write_pointer  in  AW+1  Gray write pointer, already 2-flop synchronised into read_clk (AW = $clog2(BUFFER_DEPTH)).
- data_out  in  DATA_WIDTH  buffer RAM word at read_address (asynchronous read).
- buffer_mode  in  1  0 = compensation enabled, 1 = pass-through (no insert/delete).
- add_req  in  1  level-sensitive request to insert SKP (buffer running low).
- del_req  in  1  level-sensitive request to delete SKP (buffer running high).
- read_address  out  AW+1  binary read pointer; low AW bits address the RAM.
- gray_read_pointer  out  AW+1  combinational Gray of read_address.
- empty  out  1  registered empty flag.
- level  out  AW+1  registered occupancy (write minus read, modulo 2^(AW+1)).
- rd_valid  out  1  data_out sampled this cycle is a valid output symbol.
- insert  out  1  pulse: this cycle repeats a SKP.
- skp_added  out  1  sticky: an insertion occurred in the current SKP run.
- skp_removed  out  1  pulse: a SKP was dropped this cycle.

Behaviour:
- Only one clock is used: read_clk. Reset is synchronous and active-high on rst.
- Reset values:
  - read_address = 0, empty = 1, level = 0, rd_valid = 0.
  - insert = 0, skp_added = 0, skp_removed = 0.
  - Internal ins_cnt = 0, run_cnt = 0.
  - rst asserted mid-operation discards all compensation state at that edge.
- Combinational signals:
  - wr_bin = gray2bin(gray_write_pointer).
  - is_skp = (data_out == SKP_RD_NEG) | (data_out == SKP_RD_POS).
- The action for each cycle is decided from the current registered empty, data_out and requests, in this priority:
  1. empty = 1: HOLD. Pointer unchanged, rd_valid <= 0.
  2. buffer_mode = 1, or add_req and del_req both high: ADV (a normal advance; conflicting requests are ignored).
  3. add_req & is_skp & ins_cnt < MAX_INS: INS. Pointer held, rd_valid <= 1, insert <= 1, skp_added <= 1, ins_cnt++.
  4. del_req & is_skp & run_cnt >= MIN_SKP_KEEP & level >= 2: DEL. Pointer +1, rd_valid <= 0, skp_removed <= 1.
  5. Otherwise: ADV. Pointer +1, rd_valid <= 1, insert <= 0.
- Run tracking:
  - On ADV of a SKP: run_cnt++ (saturating).
  - On ADV of a non-SKP: run_cnt, ins_cnt and skp_added clear.
  - INS does not change run_cnt.
- Pointer and flag arithmetic:
  - Pointer increments wrap modulo 2^(AW+1); the MSB toggles on wrap.
  - empty <= (rd_nxt == wr_bin), where rd_nxt is the next-state pointer, so no stale-read cycle follows the last word.
  - level <= wr_bin - rd_nxt (AW+1 bits, modulo).
  - A full buffer (level = BUFFER_DEPTH) must not assert empty.
- Latency: one read_clk cycle from data_out presentation to the rd_valid/insert/skp_removed decision.
- Write-pointer synchroniser lag may under-report level; this is safe (deletion is conservative).

Decomposition:
- Shared package eb_pkg: SKP_RD_NEG/SKP_RD_POS constants, DATA_WIDTH default, action enum {HOLD, ADV, INS, DEL}.
- One sub-module: eb_gray_to_bin (parametrised width) for wr_bin. gray_read_pointer uses the existing binary-to-Gray converter.

Test Plan:
- Reset then write 5 non-SKP words -> read_address steps 0..5, rd_valid high for 5 cycles, empty rises on the 5th advance edge, level 5→0.
- SKP at address 3 with add_req held, MAX_INS = 2 -> read_address stays at 3 for 2 cycles with insert = 1, then advances. skp_added stays 1 until the first non-SKP advances.
- Run of 3 SKPs with del_req held, MIN_SKP_KEEP = 1, level >= 2 -> first SKP passes (rd_valid = 1), next two dropped (skp_removed pulses, rd_valid = 0), pointer +3 total.
- add_req and del_req both high on a SKP -> plain advance, no insert/skp_removed. buffer_mode = 1 with add_req -> no insertion.
- Fill 16 and drain 20 words across the pointer wrap -> MSB toggles at 16, level never exceeds 16, empty is never asserted while full, Gray outputs differ by one bit per step.
- rst pulsed during an active insertion (ins_cnt = 1) -> next cycle all outputs are at reset values, empty = 1, and a subsequent SKP allows MAX_INS fresh insertions.

Source files
------------

// File: rtl/eb_pkg.sv
// Shared definitions for the RX elastic buffer: SKP encodings, default symbol
// width and the per-cycle read action.
package eb_pkg;

    localparam int EB_DATA_WIDTH = 10;

    localparam logic [EB_DATA_WIDTH-1:0] EB_SKP_RD_NEG = 10'b0011111001;
    localparam logic [EB_DATA_WIDTH-1:0] EB_SKP_RD_POS = 10'b1100000110;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        ADV  = 2'd1,
        INS  = 2'd2,
        DEL  = 2'd3
    } action_e;

endpackage

// File: rtl/eb_gray_to_bin.sv
// Gray-code to binary converter, used on the synchronised write pointer.
module eb_gray_to_bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        o_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_bin[i] = ^(i_gray >> i);
        end
    end

endmodule

// File: rtl/elastic_read_ctrl.sv
// Read-side controller for the RX elastic buffer: read pointer, fill level,
// and SKP insertion/deletion for clock compensation.
module elastic_read_ctrl
    import eb_pkg::*;
#(
    parameter int                    DATA_WIDTH   = EB_DATA_WIDTH,
    parameter int                    BUFFER_DEPTH = 16,
    parameter logic [DATA_WIDTH-1:0] SKP_RD_NEG   = EB_SKP_RD_NEG,
    parameter logic [DATA_WIDTH-1:0] SKP_RD_POS   = EB_SKP_RD_POS,
    parameter int                    MAX_INS      = 2,
    parameter int                    MIN_SKP_KEEP = 1,
    localparam int                   AW           = $clog2(BUFFER_DEPTH)
) (
    input  logic                  read_clk,
    input  logic                  rst,
    input  logic [AW:0]           gray_write_pointer,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic                  buffer_mode,
    input  logic                  add_req,
    input  logic                  del_req,
    output logic [AW:0]           read_address,
    output logic [AW:0]           gray_read_pointer,
    output logic                  empty,
    output logic [AW:0]           level,
    output logic                  rd_valid,
    output logic                  insert,
    output logic                  skp_added,
    output logic                  skp_removed
);

    localparam int INS_W = $clog2(MAX_INS + 2);
    localparam int RUN_W = $clog2(MIN_SKP_KEEP + 2);

    localparam logic [INS_W-1:0] INS_LIMIT     = INS_W'(MAX_INS);
    localparam logic [RUN_W-1:0] RUN_KEEP      = RUN_W'(MIN_SKP_KEEP);
    localparam logic [RUN_W-1:0] RUN_SAT       = '1;
    localparam logic [AW:0]      LEVEL_DEL_MIN = (AW + 1)'(2);

    logic [AW:0]      r_rd_ptr;
    logic             r_empty;
    logic [AW:0]      r_level;
    logic             r_rd_valid;
    logic             r_insert;
    logic             r_skp_added;
    logic             r_skp_removed;
    logic [INS_W-1:0] r_ins_cnt;
    logic [RUN_W-1:0] r_run_cnt;

    logic [AW:0]      w_wr_bin;
    logic             w_is_skp;
    action_e          w_action;

    logic [AW:0]      w_rd_nxt;
    logic             w_valid_nxt;
    logic             w_insert_nxt;
    logic             w_added_nxt;
    logic             w_removed_nxt;
    logic [INS_W-1:0] w_ins_nxt;
    logic [RUN_W-1:0] w_run_nxt;

    eb_gray_to_bin #(
        .WIDTH (AW + 1)
    ) u_wr_g2b (
        .i_gray (gray_write_pointer),
        .o_bin  (w_wr_bin)
    );

    assign w_is_skp = (data_out == SKP_RD_NEG) || (data_out == SKP_RD_POS);

    // Action priority: empty hold, then pass-through / conflicting requests,
    // then insertion, then deletion, else a plain advance.
    always_comb begin
        w_action = ADV;
        if (r_empty) begin
            w_action = HOLD;
        end else if (buffer_mode || (add_req && del_req)) begin
            w_action = ADV;
        end else if (add_req && w_is_skp && (r_ins_cnt < INS_LIMIT)) begin
            w_action = INS;
        end else if (del_req && w_is_skp && (r_run_cnt >= RUN_KEEP) &&
                     (r_level >= LEVEL_DEL_MIN)) begin
            w_action = DEL;
        end
    end

    always_comb begin
        w_rd_nxt      = r_rd_ptr;
        w_valid_nxt   = 1'b0;
        w_insert_nxt  = 1'b0;
        w_removed_nxt = 1'b0;
        w_added_nxt   = r_skp_added;
        w_ins_nxt     = r_ins_cnt;
        w_run_nxt     = r_run_cnt;
        case (w_action)
            HOLD: begin
                w_valid_nxt = 1'b0;
            end
            INS: begin
                w_valid_nxt  = 1'b1;
                w_insert_nxt = 1'b1;
                w_added_nxt  = 1'b1;
                w_ins_nxt    = r_ins_cnt + INS_W'(1);
            end
            DEL: begin
                w_rd_nxt      = r_rd_ptr + (AW + 1)'(1);
                w_removed_nxt = 1'b1;
            end
            default: begin
                w_rd_nxt    = r_rd_ptr + (AW + 1)'(1);
                w_valid_nxt = 1'b1;
                if (w_is_skp) begin
                    if (r_run_cnt != RUN_SAT) begin
                        w_run_nxt = r_run_cnt + RUN_W'(1);
                    end
                end else begin
                    w_run_nxt   = '0;
                    w_ins_nxt   = '0;
                    w_added_nxt = 1'b0;
                end
            end
        endcase
    end

    // Flags are computed from the next pointer so empty rises on the edge
    // that consumes the last word.
    always_ff @(posedge read_clk) begin
        if (rst) begin
            r_rd_ptr      <= '0;
            r_empty       <= 1'b1;
            r_level       <= '0;
            r_rd_valid    <= 1'b0;
            r_insert      <= 1'b0;
            r_skp_added   <= 1'b0;
            r_skp_removed <= 1'b0;
            r_ins_cnt     <= '0;
            r_run_cnt     <= '0;
        end else begin
            r_rd_ptr      <= w_rd_nxt;
            r_empty       <= (w_rd_nxt == w_wr_bin);
            r_level       <= w_wr_bin - w_rd_nxt;
            r_rd_valid    <= w_valid_nxt;
            r_insert      <= w_insert_nxt;
            r_skp_added   <= w_added_nxt;
            r_skp_removed <= w_removed_nxt;
            r_ins_cnt     <= w_ins_nxt;
            r_run_cnt     <= w_run_nxt;
        end
    end

    assign read_address      = r_rd_ptr;
    assign gray_read_pointer = r_rd_ptr ^ (r_rd_ptr >> 1);
    assign empty             = r_empty;
    assign level             = r_level;
    assign rd_valid          = r_rd_valid;
    assign insert            = r_insert;
    assign skp_added         = r_skp_added;
    assign skp_removed       = r_skp_removed;

endmodule

// File: tb/tb_elastic_read_ctrl.sv
// Bench for elastic_read_ctrl: a buffer RAM model, a cycle model of the read
// rules, a per-cycle compare process and directed scenarios with literal totals.
module tb_elastic_read_ctrl;

    localparam logic [9:0] SKP_N = 10'b0011111001;
    localparam logic [9:0] SKP_P = 10'b1100000110;

    logic       read_clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] wr_ptr = '0;
    logic [4:0] gray_write_pointer;
    logic [9:0] data_out;
    logic       buffer_mode = 1'b0;
    logic       add_req = 1'b0;
    logic       del_req = 1'b0;
    logic [4:0] read_address;
    logic [4:0] gray_read_pointer;
    logic       empty;
    logic [4:0] level;
    logic       rd_valid;
    logic       insert;
    logic       skp_added;
    logic       skp_removed;

    logic [9:0] mem [16];

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    int cnt_valid, cnt_ins, cnt_rem, cnt_added, cnt_ins_at3, cnt_lvl16, max_level;
    logic [4:0] prev_addr = '0;
    logic [4:0] prev_gray = '0;

    int m_rd, m_level, m_ins, m_run;
    bit m_empty, m_valid, m_insert, m_added, m_removed;

    always #5 read_clk = ~read_clk;

    assign gray_write_pointer = wr_ptr ^ (wr_ptr >> 1);
    assign data_out           = mem[read_address[3:0]];

    elastic_read_ctrl dut (
        .read_clk           (read_clk),
        .rst                (rst),
        .gray_write_pointer (gray_write_pointer),
        .data_out           (data_out),
        .buffer_mode        (buffer_mode),
        .add_req            (add_req),
        .del_req            (del_req),
        .read_address       (read_address),
        .gray_read_pointer  (gray_read_pointer),
        .empty              (empty),
        .level              (level),
        .rd_valid           (rd_valid),
        .insert             (insert),
        .skp_added          (skp_added),
        .skp_removed        (skp_removed)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the read rules: pointer and occupancy as plain integers modulo 32.
    always @(posedge read_clk) begin : model_step
        int         n_rd, n_ins, n_run, n_wr;
        bit         n_valid, n_insert, n_added, n_removed, skp, comp;
        logic [9:0] sym;
        if (rst) begin
            m_rd <= 0; m_empty <= 1'b1; m_level <= 0; m_valid <= 1'b0;
            m_insert <= 1'b0; m_added <= 1'b0; m_removed <= 1'b0;
            m_ins <= 0; m_run <= 0;
        end else begin
            n_rd = m_rd; n_ins = m_ins; n_run = m_run; n_added = m_added;
            n_valid = 1'b0; n_insert = 1'b0; n_removed = 1'b0;
            sym  = mem[m_rd % 16];
            skp  = (sym == SKP_N) || (sym == SKP_P);
            comp = !buffer_mode && !(add_req && del_req);
            n_wr = int'(wr_ptr);
            if (m_empty) begin
                n_valid = 1'b0;
            end else if (comp && add_req && skp && m_ins < 2) begin
                n_valid = 1'b1; n_insert = 1'b1; n_added = 1'b1; n_ins = m_ins + 1;
            end else if (comp && del_req && skp && m_run >= 1 && m_level >= 2) begin
                n_rd = (m_rd + 1) % 32; n_removed = 1'b1;
            end else begin
                n_rd = (m_rd + 1) % 32; n_valid = 1'b1;
                if (skp) n_run = m_run + 1;
                else begin n_run = 0; n_ins = 0; n_added = 1'b0; end
            end
            m_rd <= n_rd; m_ins <= n_ins; m_run <= n_run;
            m_valid <= n_valid; m_insert <= n_insert; m_added <= n_added; m_removed <= n_removed;
            m_empty <= (n_rd == n_wr);
            m_level <= (n_wr - n_rd + 32) % 32;
        end
    end

    always @(negedge read_clk) begin
        if (check_en) begin
            chk("read_address", 32'(read_address), 32'(m_rd));
            chk("gray_read_pointer", 32'(gray_read_pointer), 32'(m_rd ^ (m_rd >> 1)));
            chk("empty", 32'(empty), 32'(m_empty));
            chk("level", 32'(level), 32'(m_level));
            chk("rd_valid", 32'(rd_valid), 32'(m_valid));
            chk("insert", 32'(insert), 32'(m_insert));
            chk("skp_added", 32'(skp_added), 32'(m_added));
            chk("skp_removed", 32'(skp_removed), 32'(m_removed));
            if (read_address == prev_addr + 5'd1)
                chk("gray_step", 32'($countones(gray_read_pointer ^ prev_gray)), 32'd1);
            prev_addr = read_address;
            prev_gray = gray_read_pointer;
            cnt_valid += int'(rd_valid);
            cnt_ins   += int'(insert);
            cnt_rem   += int'(skp_removed);
            cnt_added += int'(skp_added);
            if (insert && read_address == 5'd3) cnt_ins_at3++;
            if (level == 5'd16) cnt_lvl16++;
            if (int'(level) > max_level) max_level = int'(level);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge read_clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        cnt_valid = 0; cnt_ins = 0; cnt_rem = 0; cnt_added = 0;
        cnt_ins_at3 = 0; cnt_lvl16 = 0; max_level = 0;
    endtask

    task automatic push(input logic [9:0] s);
        mem[wr_ptr[3:0]] = s;
        wr_ptr = wr_ptr + 5'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_ptr = '0;
        add_req = 1'b0; del_req = 1'b0; buffer_mode = 1'b0;
        tick(2);
        rst = 1'b0;
        clear_counts();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 10'h000;
        clear_counts();
        do_reset();
        check_en = 1'b1;
        chk("reset_read_address", 32'(read_address), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_level", 32'(level), 32'd0);

        // Five plain words
        for (int i = 1; i <= 5; i++) push(10'(i));
        tick(8);
        chk("s1_valid_count", 32'(cnt_valid), 32'd5);
        chk("s1_final_addr", 32'(read_address), 32'd5);
        chk("s1_max_level", 32'(max_level), 32'd5);
        chk("s1_empty", 32'(empty), 32'd1);

        // SKP at address 3 with add_req held
        do_reset();
        push(10'h011); push(10'h012); push(10'h013); push(SKP_N); push(10'h014); push(10'h015);
        add_req = 1'b1;
        tick(12);
        add_req = 1'b0;
        chk("s2_insert_count", 32'(cnt_ins), 32'd2);
        chk("s2_insert_at_3", 32'(cnt_ins_at3), 32'd2);
        chk("s2_added_cycles", 32'(cnt_added), 32'd3);
        chk("s2_valid_count", 32'(cnt_valid), 32'd8);
        chk("s2_final_addr", 32'(read_address), 32'd6);

        // SKP run of three with del_req held
        do_reset();
        push(10'h021); push(SKP_N); push(SKP_P); push(SKP_N); push(10'h022); push(10'h023);
        del_req = 1'b1;
        tick(10);
        del_req = 1'b0;
        chk("s3_removed_count", 32'(cnt_rem), 32'd2);
        chk("s3_valid_count", 32'(cnt_valid), 32'd4);
        chk("s3_final_addr", 32'(read_address), 32'd6);

        // Conflicting requests on a SKP
        do_reset();
        push(10'h031); push(SKP_N); push(10'h032);
        add_req = 1'b1; del_req = 1'b1;
        tick(6);
        add_req = 1'b0; del_req = 1'b0;
        chk("s4a_insert_count", 32'(cnt_ins + cnt_rem), 32'd0);
        chk("s4a_valid_count", 32'(cnt_valid), 32'd3);

        // Pass-through mode ignores add_req
        do_reset();
        push(10'h041); push(SKP_P); push(SKP_P); push(10'h042);
        buffer_mode = 1'b1; add_req = 1'b1;
        tick(7);
        buffer_mode = 1'b0; add_req = 1'b0;
        chk("s4b_insert_count", 32'(cnt_ins + cnt_added), 32'd0);
        chk("s4b_valid_count", 32'(cnt_valid), 32'd4);

        // Fill 16 at once, drain across the pointer MSB, then 4 more
        do_reset();
        for (int i = 0; i < 16; i++) push(10'(10'h100 + i));
        tick(20);
        chk("s5_addr_at_16", 32'(read_address), 32'd16);
        chk("s5_full_cycles", 32'(cnt_lvl16), 32'd1);
        for (int i = 0; i < 4; i++) push(10'(10'h200 + i));
        tick(8);
        chk("s5_valid_count", 32'(cnt_valid), 32'd20);
        chk("s5_final_addr", 32'(read_address), 32'd20);
        chk("s5_max_level", 32'(max_level), 32'd16);

        // Reset during an insertion, then fresh insertions
        do_reset();
        push(10'h051); push(SKP_N); push(10'h052);
        add_req = 1'b1;
        tick(3);
        chk("s6_insert_active", 32'(insert), 32'd1);
        chk("s6_addr_active", 32'(read_address), 32'd1);
        rst = 1'b1;
        wr_ptr = '0;
        tick(1);
        rst = 1'b0;
        chk("s6_rst_addr", 32'(read_address), 32'd0);
        chk("s6_rst_empty", 32'(empty), 32'd1);
        chk("s6_rst_flags", 32'({insert, skp_added, skp_removed, rd_valid}), 32'd0);
        chk("s6_rst_level", 32'(level), 32'd0);
        clear_counts();
        push(10'h053); push(SKP_P); push(10'h054);
        tick(10);
        add_req = 1'b0;
        chk("s6_fresh_inserts", 32'(cnt_ins), 32'd2);
        chk("s6_valid_count", 32'(cnt_valid), 32'd5);
        chk("s6_final_addr", 32'(read_address), 32'd3);

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
